cache_ctrl: RTL

//   Read-only request sequencer in front of the cache array. Accepts one read at a time.

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/cache_victim_sel.sv | 31 +++
 rtl/cache_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg: shared geometry, block types and controller state encoding.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

  localparam int SetWidth      = 4;
  localparam int TagWidth      = 8;
  localparam int DataWidth     = 32;
  localparam int Associativity = 4;
  localparam int WayWidth      = $clog2(Associativity);
  localparam int NumSets       = 1 << SetWidth;
  localparam int AddrWidth     = TagWidth + SetWidth;

  typedef logic [DataWidth-1:0] block_data_t;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  typedef struct packed {
    logic [TagWidth-1:0] tag;
    logic [SetWidth-1:0] set;
  } addr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MREQ   = 3'd2,
    ST_MWAIT  = 3'd3,
    ST_FILL   = 3'd4,
    ST_RESP   = 3'd5
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/cache_victim_sel.sv
// -----------------------------------------------------------------------------
// cache_victim_sel: picks the way to replace in one set (combinational).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cache_victim_sel
  import cache_pkg::*;
#(
  parameter bit FillFirstInvalid = 1'b1
) (
  input  logic [Associativity-1:0] valid_i,
  input  logic [WayWidth-1:0]      rr_ptr_i,
  output logic [WayWidth-1:0]      victim_o,
  output logic                     has_invalid_o
);

  // Descending scan so the lowest invalid way is the last (winning) assignment.
  always_comb begin
    victim_o      = rr_ptr_i;
    has_invalid_o = ~&valid_i;
    if (FillFirstInvalid) begin
      for (int w = Associativity - 1; w >= 0; w--) begin
        if (!valid_i[w]) victim_o = WayWidth'(w);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl: single-outstanding read sequencer (hit answer / miss fetch+fill).
// Optional macro CACHE_CTRL_STATS_EN adds saturating hit/miss counters.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cache_ctrl
  import cache_pkg::*;
#(
  parameter int StatsWidth       = 32,
  parameter bit FillFirstInvalid = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_data_o,
  output logic                 resp_miss_o,
  output logic [SetWidth-1:0]  cache_set_o,
  output logic [TagWidth-1:0]  cache_tag_o,
  input  logic                 cache_hit_i,
  input  logic [DataWidth-1:0] cache_data_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  input  logic                 mem_resp_valid_i,
  input  logic [DataWidth-1:0] mem_resp_data_i,
  output logic                 fill_en_o,
  output logic [SetWidth-1:0]  fill_set_o,
  output logic [WayWidth-1:0]  fill_way_o,
  output block_info_t          fill_info_o,
  output block_data_t          fill_data_o
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [StatsWidth-1:0] hit_count_o,
  output logic [StatsWidth-1:0] miss_count_o
`endif
);

  ctrl_state_e               state_q, state_d;
  addr_t                     addr_q, addr_d;
  block_data_t               data_q, data_d;
  logic                      miss_q, miss_d;
  logic [WayWidth-1:0]       rr_q;
  logic [Associativity-1:0]  valid_q [NumSets];
  logic [WayWidth-1:0]       victim;
  logic                      has_invalid;

  cache_victim_sel #(
    .FillFirstInvalid(FillFirstInvalid)
  ) u_victim_sel (
    .valid_i      (valid_q[addr_q.set]),
    .rr_ptr_i     (rr_q),
    .victim_o     (victim),
    .has_invalid_o(has_invalid)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    miss_d          = miss_q;
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    fill_en_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = addr_t'(req_addr_i);
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cache_hit_i) begin
          data_d  = cache_data_i;
          miss_d  = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MREQ;
        end
      end
      ST_MREQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (mem_resp_valid_i) begin
          data_d  = mem_resp_data_i;
          miss_d  = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_en_o = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      miss_q  <= 1'b0;
      rr_q    <= '0;
      for (int s = 0; s < NumSets; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      miss_q  <= miss_d;
      if (fill_en_o) begin
        valid_q[addr_q.set][victim] <= 1'b1;
        // Invalid-first mode only rotates once the set is full.
        if (!FillFirstInvalid || !has_invalid) begin
          rr_q <= (rr_q == WayWidth'(Associativity - 1)) ? '0 : rr_q + WayWidth'(1);
        end
      end
    end
  end

  assign resp_data_o    = data_q;
  assign resp_miss_o    = miss_q;
  assign cache_set_o    = addr_q.set;
  assign cache_tag_o    = addr_q.tag;
  assign mem_req_addr_o = addr_q;
  assign fill_set_o     = addr_q.set;
  assign fill_way_o     = victim;
  assign fill_info_o    = '{valid: (state_q == ST_FILL), tag: addr_q.tag};
  assign fill_data_o    = data_q;

`ifdef CACHE_CTRL_STATS_EN
  logic [StatsWidth-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_valid_o && resp_ready_i) begin
      if (miss_q) begin
        if (~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + StatsWidth'(1);
      end else begin
        if (~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + StatsWidth'(1);
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

`default_nettype wire
